// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA engine.
//
// A CPU write to FF46 pulses `start`. The engine then copies BYTES bytes from
// source page {page, 8'h00} into OAM at FE00 + idx, one byte per five-cycle
// slot: REQ, RD0, RD1, CAP and WR. Each slot can stall in REQ until the arbiter
// grants the bus.
//
// Ports:
//   clock, reset_n   - system clock (rising edge) and asynchronous active-low reset
//   start, dmaAdress - trigger pulse and the source page, sampled together
//   bus_gnt, Di_src  - arbiter grant and source read data (two-cycle latency)
//   bus_req, A_src,
//   rd_src           - bus request, source address and source read strobe
//   A_oam, Do_oam,
//   wr_oam           - OAM write address, write data and write strobe
//   busy, done       - transfer in progress, one-cycle completion pulse
//
// Every output comes from a flop. Each output flop is loaded from the next
// state, so an output is aligned with the state that the FSM occupies in the
// same cycle.

module oam_dma #(
    parameter int unsigned BYTES       = 160,
    parameter int unsigned START_DELAY = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  dmaAdress,
    input  logic        bus_gnt,
    input  logic [7:0]  Di_src,
    output logic        bus_req,
    output logic [15:0] A_src,
    output logic        rd_src,
    output logic [15:0] A_oam,
    output logic [7:0]  Do_oam,
    output logic        wr_oam,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DlyW    = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;
    localparam logic [7:0]  LastIdx = 8'(BYTES - 1);
    localparam logic [DlyW-1:0] LastDly = DlyW'(START_DELAY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StReq,
        StRd0,
        StRd1,
        StCap,
        StWr
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      page_q, page_d;
    logic [7:0]      idx_q, idx_d;
    logic [DlyW-1:0] dly_q, dly_d;
    logic [7:0]      data_q, data_d;

    logic            bus_req_q, bus_req_d;
    logic [15:0]     a_src_q, a_src_d;
    logic            rd_src_q, rd_src_d;
    logic [15:0]     a_oam_q, a_oam_d;
    logic [7:0]      do_oam_q, do_oam_d;
    logic            wr_oam_q, wr_oam_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Pages E0..FF are echo RAM; fold them down onto C0..DF.
    logic [7:0] start_page;
    assign start_page = (dmaAdress < 8'hE0) ? dmaAdress : (dmaAdress - 8'h20);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        data_d  = data_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StDelay: begin
                if (dly_q == LastDly) begin
                    state_d = StReq;
                end else begin
                    dly_d = dly_q + DlyW'(1);
                end
            end
            StReq: begin
                // The grant is only checked here. Once a read starts, the byte finishes.
                if (bus_gnt) begin
                    state_d = StRd0;
                end
            end
            StRd0: begin
                state_d = StRd1;
            end
            StRd1: begin
                state_d = StCap;
            end
            StCap: begin
                data_d  = Di_src;
                state_d = StWr;
            end
            StWr: begin
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A new trigger always restarts the transfer. A WR that is already on the
        // outputs still completes, but it does not produce a done pulse.
        if (start) begin
            state_d = StDelay;
            page_d  = start_page;
            idx_d   = 8'h00;
            dly_d   = '0;
            done_d  = 1'b0;
        end
    end

    // Output values for the cycle in which the FSM is in state_d.
    always_comb begin
        busy_d    = (state_d != StIdle);
        bus_req_d = busy_d;
        rd_src_d  = (state_d == StRd0) || (state_d == StRd1) || (state_d == StCap);
        wr_oam_d  = (state_d == StWr);
        a_src_d   = rd_src_d ? {page_d, idx_d} : a_src_q;
        a_oam_d   = wr_oam_d ? (16'hFE00 + {8'h00, idx_d}) : a_oam_q;
        do_oam_d  = wr_oam_d ? data_d : do_oam_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            page_q    <= 8'h00;
            idx_q     <= 8'h00;
            dly_q     <= '0;
            data_q    <= 8'h00;
            bus_req_q <= 1'b0;
            a_src_q   <= 16'h0000;
            rd_src_q  <= 1'b0;
            a_oam_q   <= 16'h0000;
            do_oam_q  <= 8'h00;
            wr_oam_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            dly_q     <= dly_d;
            data_q    <= data_d;
            bus_req_q <= bus_req_d;
            a_src_q   <= a_src_d;
            rd_src_q  <= rd_src_d;
            a_oam_q   <= a_oam_d;
            do_oam_q  <= do_oam_d;
            wr_oam_q  <= wr_oam_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus_req = bus_req_q;
    assign A_src   = a_src_q;
    assign rd_src  = rd_src_q;
    assign A_oam   = a_oam_q;
    assign Do_oam  = do_oam_q;
    assign wr_oam  = wr_oam_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
